// File: rtl/serial_mag_compare_ctrl.sv
// Serial unsigned magnitude comparator.
// A single 2-bit compare slice is reused once per cycle, starting at the MSB
// slice. A small controller handles the start/done handshake, steps the slice
// index, accumulates the verdict and holds the result until the next start.
module serial_mag_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int NS        = WIDTH / 2,
  localparam int CW        = $clog2(NS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inStart,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             outBusy,
  output logic             outDone,
  output logic             outGT,
  output logic             outEQ,
  output logic             outLT,
  output logic [CW-1:0]    outCycles
);

  // Index width; NS=1 still needs a one-bit index register.
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [CW-1:0]    cycles_reg, cycles_next;
  logic             gt_reg, gt_next;
  logic             eq_reg, eq_next;
  logic             lt_reg, lt_next;
  // First unequal slice verdict, only meaningful when all slices are walked.
  logic             rec_gt_reg, rec_gt_next;
  logic             rec_lt_reg, rec_lt_next;

  // Captured operands split into 2-bit slices.
  logic [1:0] a_slice [NS];
  logic [1:0] b_slice [NS];

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[2*gi+1:2*gi];
      assign b_slice[gi] = b_reg[2*gi+1:2*gi];
    end
  endgenerate

  // The one shared slice comparator, fed by the currently indexed slice pair.
  logic [1:0] cur_a, cur_b;
  logic       slice_gt, slice_lt, slice_ne;
  logic       rec_any, fin_gt, fin_lt;

  assign cur_a    = a_slice[idx_reg];
  assign cur_b    = b_slice[idx_reg];
  assign slice_gt = (cur_a > cur_b);
  assign slice_lt = (cur_a < cur_b);
  assign slice_ne = slice_gt | slice_lt;

  // Final verdict when the last slice is reached: an earlier recorded verdict
  // wins, otherwise the last slice decides, otherwise the operands are equal.
  assign rec_any = rec_gt_reg | rec_lt_reg;
  assign fin_gt  = rec_gt_reg | (~rec_any & slice_gt);
  assign fin_lt  = rec_lt_reg | (~rec_any & slice_lt);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers: operands, index, cycle count, verdicts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      idx_reg    <= IW'(NS - 1);
      cycles_reg <= '0;
      gt_reg     <= 1'b0;
      eq_reg     <= 1'b0;
      lt_reg     <= 1'b0;
      rec_gt_reg <= 1'b0;
      rec_lt_reg <= 1'b0;
    end else begin
      a_reg      <= a_next;
      b_reg      <= b_next;
      idx_reg    <= idx_next;
      cycles_reg <= cycles_next;
      gt_reg     <= gt_next;
      eq_reg     <= eq_next;
      lt_reg     <= lt_next;
      rec_gt_reg <= rec_gt_next;
      rec_lt_reg <= rec_lt_next;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    idx_next    = idx_reg;
    cycles_next = cycles_reg;
    gt_next     = gt_reg;
    eq_next     = eq_reg;
    lt_next     = lt_reg;
    rec_gt_next = rec_gt_reg;
    rec_lt_next = rec_lt_reg;

    unique case (state_reg)
      IDLE: begin
        if (inStart) begin
          a_next      = inA;
          b_next      = inB;
          idx_next    = IW'(NS - 1);
          cycles_next = '0;
          gt_next     = 1'b0;
          eq_next     = 1'b0;
          lt_next     = 1'b0;
          rec_gt_next = 1'b0;
          rec_lt_next = 1'b0;
          state_next  = COMPARE;
        end
      end

      COMPARE: begin
        cycles_next = cycles_reg + CW'(1);
        if (EARLY_EXIT && slice_ne) begin
          // Higher slices were equal, so this slice settles the result.
          gt_next    = slice_gt;
          lt_next    = slice_lt;
          state_next = DONE;
        end else begin
          if (!rec_any && slice_ne) begin
            rec_gt_next = slice_gt;
            rec_lt_next = slice_lt;
          end
          if (idx_reg == '0) begin
            gt_next    = fin_gt;
            lt_next    = fin_lt;
            eq_next    = ~(fin_gt | fin_lt);
            state_next = DONE;
          end else begin
            idx_next = idx_reg - IW'(1);
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign outBusy   = (state_reg == COMPARE);
  assign outDone   = (state_reg == DONE);
  assign outGT     = gt_reg;
  assign outEQ     = eq_reg;
  assign outLT     = lt_reg;
  assign outCycles = cycles_reg;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Scoreboard bench: two comparators (early exit on / off) share one stimulus
// stream; expected results come from plain unsigned arithmetic.
module tb_serial_mag_compare_ctrl;

  localparam int W  = 8;
  localparam int NS = W / 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            inStart = 1'b0;
  logic [W-1:0]    inA = '0;
  logic [W-1:0]    inB = '0;
  logic [1:0]      busy, done, gt, eq, lt;
  logic [1:0][2:0] cyc_o;

  always #5 clk = ~clk;

  serial_mag_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .reset_n(reset_n), .inStart(inStart), .inA(inA), .inB(inB),
    .outBusy(busy[0]), .outDone(done[0]), .outGT(gt[0]), .outEQ(eq[0]),
    .outLT(lt[0]), .outCycles(cyc_o[0])
  );

  serial_mag_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_fix (
    .clk(clk), .reset_n(reset_n), .inStart(inStart), .inA(inA), .inB(inB),
    .outBusy(busy[1]), .outDone(done[1]), .outGT(gt[1]), .outEQ(eq[1]),
    .outLT(lt[1]), .outCycles(cyc_o[1])
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           gt;
    bit           eq;
    bit           lt;
    int           n;
    int           at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit rst_q       = 1'b0;
  bit mon_en      = 1'b0;
  bit [1:0] h_gt  = '0;
  bit [1:0] h_eq  = '0;
  bit [1:0] h_lt  = '0;
  int h_n [2]     = '{0, 0};

  always @(posedge clk) begin
    cyc++;
    rst_q = !reset_n;
  end

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Reference: verdict from unsigned comparison; evaluations from the
  // position of the highest differing bit (early exit) or NS (fixed).
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit ee, input int k);
    exp_t         r;
    logic [W-1:0] x;
    int           hp;
    x  = a ^ b;
    hp = -1;
    for (int i = 0; i < W; i++) if (x[i]) hp = i;
    r.a  = a;
    r.b  = b;
    r.gt = (a > b);
    r.eq = (a == b);
    r.lt = (a < b);
    r.n  = (ee && hp >= 0) ? (NS - hp / 2) : NS;
    r.at = k + r.n;
    return r;
  endfunction

  task automatic mon(input int d);
    exp_t       e;
    logic [2:0] co;
    bit         empty;
    co = cyc_o[d];
    if (rst_q) begin
      h_gt[d] = 1'b0; h_eq[d] = 1'b0; h_lt[d] = 1'b0; h_n[d] = 0;
    end
    if (done[d] === 1'b1) begin
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done dut%0d: got done=1 expected done=0 (cycle %0d)", d, cyc);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check("gt", d, 32'(gt[d]), 32'(e.gt));
        check("eq", d, 32'(eq[d]), 32'(e.eq));
        check("lt", d, 32'(lt[d]), 32'(e.lt));
        check("cycles", d, 32'(co), 32'(e.n));
        check("done_cycle", d, 32'(cyc), 32'(e.at));
        check("busy_in_done", d, 32'(busy[d]), 32'd0);
        h_gt[d] = e.gt; h_eq[d] = e.eq; h_lt[d] = e.lt; h_n[d] = e.n;
        $display("dut%0d A=%02h B=%02h -> gt=%0d eq=%0d lt=%0d cycles=%0d at cycle %0d",
                 d, e.a, e.b, gt[d], eq[d], lt[d], co, cyc);
      end
    end else if (busy[d] === 1'b1) begin
      check("result_during_busy", d, {29'd0, gt[d], eq[d], lt[d]}, 32'd0);
    end else begin
      check("hold", d, {26'd0, gt[d], eq[d], lt[d], co},
            {26'd0, h_gt[d], h_eq[d], h_lt[d], 3'(h_n[d])});
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    while ((busy !== 2'b00 || done !== 2'b00) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy=%b done=%b expected 00/00 (cycle %0d)", busy, done, cyc);
    end
  endtask

  // Drives one start pulse at a negedge; the following edge accepts it.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    inA     = a;
    inB     = b;
    inStart = 1'b1;
    q0.push_back(model(a, b, 1'b1, cyc + 1));
    q1.push_back(model(a, b, 1'b0, cyc + 1));
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    start_op(a, b);
    @(negedge clk);
    inStart = 1'b0;
    inA     = 8'($urandom);
    inB     = 8'($urandom);
  endtask

  task automatic check_all_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      check(name, d, {26'd0, busy[d], done[d], gt[d], eq[d], lt[d], 1'b0} | 32'(cyc_o[d]), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    int           mode;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_all_zero("reset_state");
    mon_en = 1'b1;

    issue(8'hA5, 8'h5A);
    issue(8'h3C, 8'h3C);
    issue(8'h34, 8'h37);
    issue(8'hC0, 8'h40);

    for (int i = 0; i < 150; i++) begin
      a    = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 3);
      if (mode == 0)      b = a;
      else if (mode == 1) b = a ^ (8'd1 << $urandom_range(0, 7));
      else                b = 8'($urandom_range(0, 255));
      issue(a, b);
    end

    // Operand change and a second start while busy are both ignored.
    wait_idle();
    start_op(8'h10, 8'h20);
    @(negedge clk);
    inA     = 8'hFF;
    inStart = 1'b1;
    @(negedge clk);
    inStart = 1'b0;

    // Reset in the middle of a compare aborts it without a done pulse.
    wait_idle();
    start_op(8'h3C, 8'h3C);
    @(negedge clk);
    inStart = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset_n = 1'b1;
    check_all_zero("after_abort");
    issue(8'h01, 8'h00);

    wait_idle();
    repeat (3) @(negedge clk);
    check("pending_ee", 0, 32'(q0.size()), 32'd0);
    check("pending_fixed", 1, 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
